// File: rtl/vga_pattern_gen.sv
// rtl/vga_pattern_gen.sv - VGA timing plus six colour test patterns; define VGA_DEBOUNCE_EN to debounce the md button
module vga_pattern_gen #(
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33,
    parameter int CLK_DIV  = 2,
    parameter int CW       = 1,
    parameter int CHK_LOG2 = 5,
    parameter int DB_CNT   = 1000000
) (
    input  logic            clk50m,
    input  logic            rst_n,
    input  logic            md,
    output logic            hs,
    output logic            vs,
    output logic [3*CW-1:0] rgbout,
    output logic            de,
    output logic            frame_start,
    output logic [2:0]      mode
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int HW      = $clog2(H_TOTAL);
    localparam int VW      = $clog2(V_TOTAL);
    // Bars need at least one pixel/line each, even for tiny test rasters
    localparam int XCELL   = (H_ACTIVE / 8 > 0) ? H_ACTIVE / 8 : 1;
    localparam int YCELL   = (V_ACTIVE / 8 > 0) ? V_ACTIVE / 8 : 1;
    localparam int XCW     = $clog2(XCELL + 1);
    localparam int YCW     = $clog2(YCELL + 1);

    logic pix_ce;

    generate
        if (CLK_DIV > 1) begin : g_div
            localparam int DW = $clog2(CLK_DIV);
            logic [DW-1:0] div_q;
            always_ff @(posedge clk50m or negedge rst_n) begin
                if (!rst_n) begin
                    div_q <= '0;
                end else if (div_q == DW'(CLK_DIV - 1)) begin
                    div_q <= '0;
                end else begin
                    div_q <= div_q + 1'b1;
                end
            end
            assign pix_ce = (div_q == DW'(CLK_DIV - 1));
        end else begin : g_nodiv
            assign pix_ce = 1'b1;
        end
    endgenerate

    logic [HW-1:0]  hcnt_q;
    logic [VW-1:0]  vcnt_q;
    logic [XCW-1:0] xcell_q;
    logic [YCW-1:0] ycell_q;
    logic [2:0]     xbar_q;
    logic [2:0]     ybar_q;
    logic           h_last;
    logic           v_last;
    logic           frame_end;

    assign h_last    = (32'(hcnt_q) == H_TOTAL - 1);
    assign v_last    = (32'(vcnt_q) == V_TOTAL - 1);
    assign frame_end = pix_ce & h_last & v_last;

    // xbar/ybar follow hcnt/vcnt as saturating bar indices, no dividers
    always_ff @(posedge clk50m or negedge rst_n) begin
        if (!rst_n) begin
            hcnt_q  <= '0;
            vcnt_q  <= '0;
            xcell_q <= '0;
            ycell_q <= '0;
            xbar_q  <= 3'd0;
            ybar_q  <= 3'd0;
        end else if (pix_ce) begin
            if (h_last) begin
                hcnt_q  <= '0;
                xcell_q <= '0;
                xbar_q  <= 3'd0;
                if (v_last) begin
                    vcnt_q  <= '0;
                    ycell_q <= '0;
                    ybar_q  <= 3'd0;
                end else begin
                    vcnt_q <= vcnt_q + 1'b1;
                    if (ycell_q == YCW'(YCELL - 1)) begin
                        ycell_q <= '0;
                        if (ybar_q != 3'd7) ybar_q <= ybar_q + 3'd1;
                    end else begin
                        ycell_q <= ycell_q + 1'b1;
                    end
                end
            end else begin
                hcnt_q <= hcnt_q + 1'b1;
                if (xcell_q == XCW'(XCELL - 1)) begin
                    xcell_q <= '0;
                    if (xbar_q != 3'd7) xbar_q <= xbar_q + 3'd1;
                end else begin
                    xcell_q <= xcell_q + 1'b1;
                end
            end
        end
    end

    logic md_s1_q;
    logic md_s2_q;
    logic md_qual;
    logic md_prev_q;
    logic md_rise;
    logic req_q;
    logic [2:0] mode_q;

`ifdef VGA_DEBOUNCE_EN
    localparam int DBW = $clog2(DB_CNT + 1);
    logic [DBW-1:0] db_cnt_q;
    logic           db_q;

    // db_q follows md_s2_q only after DB_CNT consecutive cycles of disagreement
    always_ff @(posedge clk50m or negedge rst_n) begin
        if (!rst_n) begin
            db_cnt_q <= '0;
            db_q     <= 1'b0;
        end else if (md_s2_q == db_q) begin
            db_cnt_q <= '0;
        end else if (32'(db_cnt_q) == DB_CNT - 1) begin
            db_cnt_q <= '0;
            db_q     <= md_s2_q;
        end else begin
            db_cnt_q <= db_cnt_q + 1'b1;
        end
    end
    assign md_qual = db_q;
`else
    assign md_qual = md_s2_q;
`endif

    assign md_rise = md_qual & ~md_prev_q;

    // Requests collapse into one pending flag consumed at the frame boundary
    always_ff @(posedge clk50m or negedge rst_n) begin
        if (!rst_n) begin
            md_s1_q   <= 1'b0;
            md_s2_q   <= 1'b0;
            md_prev_q <= 1'b0;
            req_q     <= 1'b0;
            mode_q    <= 3'd0;
        end else begin
            md_s1_q   <= md;
            md_s2_q   <= md_s1_q;
            md_prev_q <= md_qual;
            if (frame_end) begin
                if (req_q) mode_q <= (mode_q == 3'd5) ? 3'd0 : mode_q + 3'd1;
                req_q <= md_rise;
            end else if (md_rise) begin
                req_q <= 1'b1;
            end
        end
    end

    logic h_chk;
    logic v_chk;

    generate
        if (CHK_LOG2 < HW) begin : g_hchk
            assign h_chk = hcnt_q[CHK_LOG2];
        end else begin : g_hchk0
            assign h_chk = 1'b0;
        end
        if (CHK_LOG2 < VW) begin : g_vchk
            assign v_chk = vcnt_q[CHK_LOG2];
        end else begin : g_vchk0
            assign v_chk = 1'b0;
        end
    endgenerate

    logic [2:0]      xinv;
    logic [2:0]      yinv;
    logic [2:0]      code_d;
    logic            de_d;
    logic            hs_d;
    logic            vs_d;
    logic            fs_d;
    logic [3*CW-1:0] rgb_d;

    assign xinv = 3'd7 - xbar_q;
    assign yinv = 3'd7 - ybar_q;

    always_comb begin
        code_d = 3'd0;
        case (mode_q)
            3'd0:    code_d = xinv;
            3'd1:    code_d = yinv;
            3'd2:    code_d = xinv ^ yinv;
            3'd3:    code_d = ~(xinv ^ yinv);
            3'd4:    code_d = (h_chk ^ v_chk) ? 3'd7 : 3'd0;
            3'd5:    code_d = 3'd7;
            default: code_d = 3'd0;
        endcase
    end

    assign de_d  = (32'(hcnt_q) < H_ACTIVE) && (32'(vcnt_q) < V_ACTIVE);
    assign hs_d  = !((32'(hcnt_q) >= H_ACTIVE + H_FP) &&
                     (32'(hcnt_q) <  H_ACTIVE + H_FP + H_SYNC));
    assign vs_d  = !((32'(vcnt_q) >= V_ACTIVE + V_FP) &&
                     (32'(vcnt_q) <  V_ACTIVE + V_FP + V_SYNC));
    assign fs_d  = (hcnt_q == '0) && (vcnt_q == '0);
    assign rgb_d = de_d ? {{CW{code_d[2]}}, {CW{code_d[1]}}, {CW{code_d[0]}}} : '0;

    logic            hs_q;
    logic            vs_q;
    logic            de_q;
    logic            fs_q;
    logic [3*CW-1:0] rgb_q;
    logic [2:0]      mode_out_q;

    // Mode output is pipelined with the pixels so it changes together with frame_start
    always_ff @(posedge clk50m or negedge rst_n) begin
        if (!rst_n) begin
            hs_q       <= 1'b1;
            vs_q       <= 1'b1;
            de_q       <= 1'b0;
            fs_q       <= 1'b0;
            rgb_q      <= '0;
            mode_out_q <= 3'd0;
        end else if (pix_ce) begin
            hs_q       <= hs_d;
            vs_q       <= vs_d;
            de_q       <= de_d;
            fs_q       <= fs_d;
            rgb_q      <= rgb_d;
            mode_out_q <= mode_q;
        end
    end

    assign hs          = hs_q;
    assign vs          = vs_q;
    assign de          = de_q;
    assign frame_start = fs_q;
    assign rgbout      = rgb_q;
    assign mode        = mode_out_q;

endmodule

// File: tb/tb_vga_pattern_gen.sv
// tb/tb_vga_pattern_gen.sv - scoreboard bench for vga_pattern_gen on small rasters
module tb_vga_pattern_gen;

    localparam int HA = 16, HFP = 2, HSW = 3, HBP = 3;
    localparam int VA = 16, VFP = 2, VSW = 2, VBP = 2;
    localparam int DIV = 2, CHK = 1;
    localparam int HT = HA + HFP + HSW + HBP;
    localparam int VT = VA + VFP + VSW + VBP;
    localparam int N  = HT * VT;
    localparam int NF = 9;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n, md, hs, vs, de, fs;
    logic [5:0] rgb;
    logic [2:0] mode;
    logic        rst2_n, md2, hs2, vs2, de2, fs2;
    logic [11:0] rgb2;
    logic [2:0]  mode2;

    vga_pattern_gen #(
        .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HSW), .H_BP(HBP),
        .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VSW), .V_BP(VBP),
        .CLK_DIV(DIV), .CW(2), .CHK_LOG2(CHK), .DB_CNT(8)
    ) dut (
        .clk50m(clk), .rst_n(rst_n), .md(md), .hs(hs), .vs(vs),
        .rgbout(rgb), .de(de), .frame_start(fs), .mode(mode)
    );

    vga_pattern_gen #(
        .H_ACTIVE(8), .H_FP(2), .H_SYNC(2), .H_BP(2),
        .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(1),
        .CLK_DIV(1), .CW(4), .CHK_LOG2(1), .DB_CNT(8)
    ) dut2 (
        .clk50m(clk), .rst_n(rst2_n), .md(md2), .hs(hs2), .vs(vs2),
        .rgbout(rgb2), .de(de2), .frame_start(fs2), .mode(mode2)
    );

    typedef struct packed {
        logic       hs;
        logic       vs;
        logic       de;
        logic       fs;
        logic [2:0] mode;
        logic [5:0] rgb;
    } pix_t;

    pix_t exp_q[$];
    int   pulses[NF];
    int   fmode[NF+1];
    int   checks   = 0;
    int   failures = 0;
    int   cyc      = 0;

    always @(posedge clk) begin
        if (!rst_n) cyc <= 0;
        else        cyc <= cyc + 1;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, expv);
        end
    endtask

    function automatic pix_t model(input int j, input int m);
        pix_t p;
        int h, v, xb, yb, code;
        logic [2:0] cb;
        h  = j % HT;
        v  = (j / HT) % VT;
        xb = h / (HA / 8); if (xb > 7) xb = 7;
        yb = v / (VA / 8); if (yb > 7) yb = 7;
        case (m)
            0:       code = 7 - xb;
            1:       code = 7 - yb;
            2:       code = (7 - xb) ^ (7 - yb);
            3:       code = 7 - ((7 - xb) ^ (7 - yb));
            4:       code = ((((h >> CHK) ^ (v >> CHK)) & 1) != 0) ? 7 : 0;
            default: code = 7;
        endcase
        cb     = 3'(code);
        p.de   = (h < HA) && (v < VA);
        p.hs   = !((h >= HA + HFP) && (h < HA + HFP + HSW));
        p.vs   = !((v >= VA + VFP) && (v < VA + VFP + VSW));
        p.fs   = (h == 0) && (v == 0);
        p.mode = 3'(m);
        p.rgb  = p.de ? {{2{cb[2]}}, {2{cb[1]}}, {2{cb[0]}}} : 6'd0;
        return p;
    endfunction

    task automatic wait_cyc(input int t);
        int guard = 0;
        while (cyc < t && guard < 4 * N * NF) begin
            @(negedge clk);
            guard++;
        end
    endtask

    task automatic monitor(input int npix);
        int   got = 0;
        int   guard = 0;
        pix_t a, e;
        while (got < npix && guard < npix * DIV + 20) begin
            @(negedge clk);
            guard++;
            if (cyc > 0 && cyc % DIV == 0) begin
                a = {hs, vs, de, fs, mode, rgb};
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL scoreboard_empty actual=%0h expected=none", a);
                end else begin
                    e = exp_q.pop_front();
                    check($sformatf("pixel%0d", got), 32'(a), 32'(e));
                end
                got++;
            end
        end
        if (got < npix) check("monitor_timeout", 32'(got), 32'(npix));
    endtask

    task automatic drive_pulses();
        int start, w;
        for (int f = 0; f < NF; f++) begin
            for (int k = 0; k < pulses[f]; k++) begin
                start = 2 * f * N + 50 + k * 200 + int'($urandom_range(0, 60));
                w     = 20 + int'($urandom_range(0, 20));
                wait_cyc(start);
                md = 1'b1;
                wait_cyc(start + w);
                md = 1'b0;
            end
`ifdef VGA_DEBOUNCE_EN
            wait_cyc(2 * f * N + 750);
            md = 1'b1;
            wait_cyc(2 * f * N + 755);
            md = 1'b0;
`endif
        end
    endtask

    localparam logic [12:0] RST_VAL = {1'b1, 1'b1, 1'b0, 1'b0, 3'd0, 6'd0};

    initial begin
        int n, de_cnt, hs_low, vs_low;
        rst_n = 1'b0; md = 1'b0; rst2_n = 1'b0; md2 = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_state", 32'({hs, vs, de, fs, mode, rgb}), 32'(RST_VAL));
        check("reset_state2", 32'({hs2, vs2, de2, fs2, mode2, rgb2}), 32'({1'b1, 1'b1, 1'b0, 1'b0, 3'd0, 12'd0}));

        pulses[0] = 1; pulses[1] = 3; pulses[2] = 1; pulses[3] = 1;
        pulses[4] = 1; pulses[5] = 2; pulses[6] = 0;
        for (int f = 7; f < NF; f++) pulses[f] = int'($urandom_range(0, 3));
        fmode[0] = 0;
        for (int f = 0; f < NF; f++)
            fmode[f+1] = (pulses[f] > 0) ? (fmode[f] + 1) % 6 : fmode[f];
        for (int j = 0; j < NF * N; j++) exp_q.push_back(model(j, fmode[j / N]));

        rst_n = 1'b1;
        @(negedge clk);
        check("no_pix_before_div", 32'({hs, vs, de, fs, mode, rgb}), 32'(RST_VAL));
        fork
            drive_pulses();
            monitor(NF * N);
        join

        wait_cyc(cyc + 317 + int'($urandom_range(0, 200)));
        #2 rst_n = 1'b0;
        #1 check("async_reset", 32'({hs, vs, de, fs, mode, rgb}), 32'(RST_VAL));
        repeat (3) @(negedge clk);
        exp_q.delete();
        for (int j = 0; j < N; j++) exp_q.push_back(model(j, 0));
        rst_n = 1'b1;
        @(negedge clk);
        check("no_glitch_release", 32'({hs, vs, de, fs, mode, rgb}), 32'(RST_VAL));
        monitor(N);

        rst2_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            repeat (100) @(negedge clk);
            md2 = 1'b1;
            repeat (30) @(negedge clk);
            md2 = 1'b0;
            repeat (120) @(negedge clk);
        end
        n = 0;
        while (mode2 != 3'd5 && n < 1000) begin @(negedge clk); n++; end
        check("dut2_mode5", 32'(mode2), 32'd5);
        n = 0;
        @(negedge clk);
        while (!fs2 && n < 300) begin @(negedge clk); n++; end
        n = 0;
        do begin @(negedge clk); n++; end while (!fs2 && n < 300);
        check("dut2_period", 32'(n), 32'd98);
        de_cnt = 0; hs_low = 0; vs_low = 0;
        for (int i = 0; i < 98; i++) begin
            if (de2) begin
                de_cnt++;
                check("dut2_rgb_active", 32'(rgb2), 32'h0FFF);
            end else begin
                check("dut2_rgb_blank", 32'(rgb2), 32'h0);
            end
            if (!hs2) hs_low++;
            if (!vs2) vs_low++;
            @(negedge clk);
        end
        check("dut2_de_count", 32'(de_cnt), 32'd32);
        check("dut2_hs_low", 32'(hs_low), 32'd14);
        check("dut2_vs_low", 32'(vs_low), 32'd14);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/vga_pattern_gen.md
VGA_PATTERN_GEN -- requirements
Module: vga_pattern_gen

Interface
REQ-001 The block SHALL expose parameter H_ACTIVE, 640, visible pixels per line.
REQ-002 The block SHALL expose parameters H_FP, H_SYNC, H_BP, 16/96/48, horizontal front porch, sync width and back porch in pixels.
REQ-003 The block SHALL expose parameter V_ACTIVE, 480, visible lines per frame.
REQ-004 The block SHALL expose parameters V_FP, V_SYNC, V_BP, 10/2/33, vertical front porch, sync width and back porch in lines.
REQ-005 The block SHALL expose parameter CLK_DIV, 2, clk50m cycles per pixel (>=1).
REQ-006 The block SHALL expose parameter CW, 1, bits per colour channel.
REQ-007 The block SHALL expose parameters CHK_LOG2, 5, checker cell size as log2 pixels; DB_CNT, 1000000, debounce length in clk50m cycles.
REQ-008 The block SHALL have ports: clk50m input 1 system clock; rst_n input 1 asynchronous active-low reset; md input 1 asynchronous mode button; hs output 1 hsync, active-low; vs output 1 vsync, active-low; rgbout output 3*CW pixel colour {R,G,B}; de output 1 display enable; frame_start output 1 one-pixel pulse at the first pixel of a frame; mode output 3 current pattern.

Function
REQ-009 pix_ce SHALL pulse for one clk50m cycle every CLK_DIV cycles; all timing state SHALL advance only on pix_ce.
REQ-010 hcnt SHALL count 0..H_TOTAL-1 (H_TOTAL=sum of the H parameters) and wrap to 0; vcnt SHALL increment only when hcnt wraps, and SHALL wrap to 0 after V_TOTAL-1.
REQ-011 hs SHALL be low when hcnt is in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC); vs SHALL be low when vcnt is in [V_ACTIVE+V_FP, V_ACTIVE+V_FP+V_SYNC).
REQ-012 de SHALL be high when hcnt<H_ACTIVE and vcnt<V_ACTIVE; rgbout SHALL be 0 whenever de is low.
REQ-013 hs, vs, de, rgbout and frame_start SHALL be registered, with exactly one pix_ce of latency from the counter values that produce them, all mutually aligned.
REQ-014 xbar=min(hcnt/(H_ACTIVE/8),7) and ybar=min(vcnt/(V_ACTIVE/8),7); xbar and ybar SHALL be tracked by incremental counters, not dividers.
REQ-015 The 3-bit colour code SHALL be: mode 0 = 7-xbar; 1 = 7-ybar; 2 = (7-xbar)^(7-ybar); 3 = ~((7-xbar)^(7-ybar)); 4 = 7 if hcnt[CHK_LOG2]^vcnt[CHK_LOG2] else 0; 5 = 7 (solid white).
REQ-016 Each code bit SHALL be replicated CW times into its channel (bit2 to R, bit1 to G, bit0 to B).
REQ-017 md SHALL pass through a 2-flop synchroniser; a rising edge of the qualified signal SHALL request a mode increment, 5 wrapping to 0.
REQ-018 A pending request SHALL be applied only at the frame boundary (hcnt=H_TOTAL-1, vcnt=V_TOTAL-1, pix_ce); multiple requests within one frame SHALL collapse into a single increment.
REQ-019 frame_start SHALL be high for exactly one pix_ce period, aligned with the output of pixel (0,0).

Reset
REQ-020 On rst_n low, all state SHALL clear immediately: counters 0, mode 0, pending request 0, synchroniser 0, hs=1, vs=1, de=0, rgbout=0, frame_start=0.
REQ-021 After rst_n is released, the first pix_ce SHALL occur CLK_DIV cycles later; a reset asserted mid-frame SHALL abort the frame without producing any glitch pulse on release.

Configuration
REQ-022 With VGA_DEBOUNCE_EN defined, the synchronised md SHALL be accepted only after it has been stable for DB_CNT consecutive clk50m cycles; without it, the synchronised md SHALL be used directly.

Verification
REQ-023 Defaults, reset released: hs low for 96 pixels per 800-pixel line; vs low for 2 lines per 525; 307200 de-high pixels per frame.
REQ-024 Mode 0: pixel x=0 gives rgbout=3'b111, x=79 gives 111, x=80 gives 110, x=560..639 gives 000, x=640 gives 000 with de=0.
REQ-025 md pulse at frame line 100: mode stays 0 for the rest of the frame and becomes 1 at the next frame_start; pixel (0,60) then gives 110.
REQ-026 Three md pulses in one frame: mode advances by exactly 1; from mode 5, one pulse returns mode to 0.
REQ-027 VGA_DEBOUNCE_EN with DB_CNT=8: a 5-cycle md glitch is ignored; a 20-cycle pulse advances mode once.
REQ-028 CLK_DIV=1, CW=4, small timing (H 8/2/2/2, V 4/1/1/1): the period equals 14x7 cycles; mode 5 gives rgbout=12'hFFF on active pixels.
